// File: rtl/crack_scheduler_pkg.sv
// Shared definitions for the NT-hash crack scheduler: FSM encoding and sizing helpers.
package crack_scheduler_pkg;

  localparam int IDX_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_DRAIN    = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  // Round-robin pointer width; a single core still needs one pointer bit.
  function automatic int calc_core_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/crack_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting just above ptr, wrapping.
module crack_scheduler_rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          any_grant
);

  // Walk offsets 1..N from the pointer; the first requesting slot wins.
  always_comb begin
    logic sel_s;
    grant     = '0;
    any_grant = 1'b0;
    sel_s     = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        sel_s     = (i == ((int'(ptr) + k) % N));
        grant[i]  = grant[i] | (sel_s & req[i] & ~any_grant);
        any_grant = any_grant | (sel_s & req[i]);
      end
    end
  end

endmodule

// File: rtl/crack_scheduler.sv
// Candidate-index scheduler: walks [first_idx, last_idx], hands one index per tick
// to a ready hash core in round-robin order, and stops on the first reported match.
module crack_scheduler
  import crack_scheduler_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = IDX_W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tick,
  input  logic                       start,
  input  logic [IDX_W-1:0]           first_idx,
  input  logic [IDX_W-1:0]           last_idx,
  input  logic [NUM_CORES-1:0]       core_ready,
  input  logic [NUM_CORES-1:0]       core_match,
  input  logic [NUM_CORES*IDX_W-1:0] core_match_idx,
  output logic [NUM_CORES-1:0]       core_valid,
  output logic [IDX_W-1:0]           core_idx,
  output logic                       busy,
  output logic                       found,
  output logic [IDX_W-1:0]           found_idx,
  output logic                       done
);

  localparam int CORE_W = calc_core_w(NUM_CORES);

  state_t              state_r;
  logic [CORE_W-1:0]   ptr_r;
  logic [IDX_W-1:0]    next_idx_r;
  logic [IDX_W-1:0]    last_idx_r;

  logic [NUM_CORES-1:0] grant_s;
  logic                 any_grant_s;
  logic [CORE_W-1:0]    grant_idx_s;
  logic [IDX_W-1:0]     match_idx_s;
  logic                 any_match_s;

  crack_scheduler_rr_arbiter #(
    .N  (NUM_CORES),
    .PW (CORE_W)
  ) u_arb (
    .req       (core_ready),
    .ptr       (ptr_r),
    .grant     (grant_s),
    .any_grant (any_grant_s)
  );

  // Encode the one-hot grant and pick the lowest-numbered matching core's index.
  always_comb begin
    grant_idx_s = '0;
    match_idx_s = '0;
    any_match_s = |core_match;
    for (int i = 0; i < NUM_CORES; i++) begin
      grant_idx_s = grant_s[i] ? CORE_W'(i) : grant_idx_s;
    end
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      match_idx_s = core_match[i] ? core_match_idx[i*IDX_W +: IDX_W] : match_idx_s;
    end
  end

  // Scheduler FSM with registered outputs; moves only on tick, core_valid pulses one clk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      ptr_r      <= CORE_W'(NUM_CORES - 1);
      next_idx_r <= '0;
      last_idx_r <= '0;
      core_valid <= '0;
      core_idx   <= '0;
      busy       <= 1'b0;
      found      <= 1'b0;
      found_idx  <= '0;
      done       <= 1'b0;
    end else begin
      core_valid <= '0;
      if (tick) begin
        case (state_r)
          S_IDLE, S_DONE: begin
            if (start) begin
              next_idx_r <= first_idx;
              last_idx_r <= last_idx;
              found      <= 1'b0;
              found_idx  <= '0;
              if (first_idx > last_idx) begin
                state_r <= S_DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                state_r <= S_DISPATCH;
                busy    <= 1'b1;
                done    <= 1'b0;
              end
            end
          end
          S_DISPATCH: begin
            if (any_match_s) begin
              found     <= 1'b1;
              found_idx <= match_idx_s;
              state_r   <= S_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else if (any_grant_s) begin
              core_valid <= grant_s;
              core_idx   <= next_idx_r;
              ptr_r      <= grant_idx_s;
              // Compare before incrementing so the top of the index space never wraps.
              if (next_idx_r == last_idx_r) begin
                state_r <= S_DRAIN;
              end else begin
                next_idx_r <= next_idx_r + IDX_W'(1);
              end
            end
          end
          S_DRAIN: begin
            if (any_match_s) begin
              found     <= 1'b1;
              found_idx <= match_idx_s;
              state_r   <= S_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else if (&core_ready) begin
              state_r <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
          default: begin
            state_r <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_crack_scheduler.sv
// Self-checking bench for crack_scheduler: dispatch scoreboard plus per-scenario status checks.
module tb_crack_scheduler;

  localparam int NC = 4;
  localparam int IW = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           tick = 1'b0;
  logic           start = 1'b0;
  logic [IW-1:0]  first_idx = '0;
  logic [IW-1:0]  last_idx = '0;
  logic [NC-1:0]  core_ready = 4'hF;
  logic [NC-1:0]  core_match = 4'h0;
  logic [NC*IW-1:0] core_match_idx = '0;
  logic [NC-1:0]  core_valid;
  logic [IW-1:0]  core_idx;
  logic           busy;
  logic           found;
  logic [IW-1:0]  found_idx;
  logic           done;

  typedef struct {
    logic [NC-1:0] valid;
    logic [IW-1:0] idx;
    int            tnum;
  } disp_t;

  disp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int tick_num = 0;

  crack_scheduler #(.NUM_CORES(NC), .IDX_W(IW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tick           (tick),
    .start          (start),
    .first_idx      (first_idx),
    .last_idx       (last_idx),
    .core_ready     (core_ready),
    .core_match     (core_match),
    .core_match_idx (core_match_idx),
    .core_valid     (core_valid),
    .core_idx       (core_idx),
    .busy           (busy),
    .found          (found),
    .found_idx      (found_idx),
    .done           (done)
  );

  always #5 clk = ~clk;

  // One clk cycle with the given tick level; any dispatch seen is popped against the scoreboard.
  task automatic step(input logic t);
    disp_t e;
    tick = t;
    if (t) tick_num++;
    @(posedge clk);
    #1;
    if (core_valid !== 4'h0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL dispatch: got core_valid=%b core_idx=%h at tick %0d, required no dispatch",
                 core_valid, core_idx, tick_num);
      end else begin
        e = exp_q.pop_front();
        if (core_valid !== e.valid || core_idx !== e.idx || tick_num !== e.tnum) begin
          bad++;
          $display("FAIL dispatch: got valid=%b idx=%h tick=%0d, required valid=%b idx=%h tick=%0d",
                   core_valid, core_idx, tick_num, e.valid, e.idx, e.tnum);
        end
      end
    end
  endtask

  task automatic expect_disp(input int core, input logic [IW-1:0] idx, input int t);
    disp_t e;
    e.valid = 4'b0001 << core;
    e.idx   = idx;
    e.tnum  = t;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    core_match = 4'h0;
    step(1'b0);
    rst_n = 1'b1;
  endtask

  task automatic launch(input logic [IW-1:0] f, input logic [IW-1:0] l);
    first_idx = f;
    last_idx = l;
    start = 1'b1;
    step(1'b1);
    start = 1'b0;
    tick_num = 0;
  endtask

  task automatic test_reset();
    core_ready = 4'hF;
    do_reset();
    total++;
    if ({core_valid, core_idx, busy, found, found_idx, done} !== 71'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h, required 0",
               {core_valid, core_idx, busy, found, found_idx, done});
    end
  endtask

  task automatic test_sequence();
    do_reset();
    core_ready = 4'hF;
    for (int k = 1; k <= 8; k++) expect_disp((k - 1) % 4, 32'd9 + 32'(k), k);
    launch(32'd10, 32'd17);
    total++;
    if ({busy, done, found} !== 3'b100) begin
      bad++;
      $display("FAIL seq_launch_status: got %b, required 100", {busy, done, found});
    end
    for (int n = 0; n < 9; n++) begin
      step(1'b0);
      step(1'b0);
      step(1'b1);
    end
    total++;
    if ({busy, done, found} !== 3'b010) begin
      bad++;
      $display("FAIL seq_end_status: got %b, required 010", {busy, done, found});
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL seq_pending: got %0d missing dispatches, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_partial_ready();
    do_reset();
    core_ready = 4'b0101;
    expect_disp(0, 32'd20, 1);
    expect_disp(2, 32'd21, 2);
    expect_disp(0, 32'd22, 4);
    expect_disp(2, 32'd23, 5);
    launch(32'd20, 32'd23);
    step(1'b1);
    step(1'b1);
    core_ready = 4'b0000;
    step(1'b1);
    core_ready = 4'b0101;
    step(1'b1);
    step(1'b1);
    step(1'b1);
    total++;
    if ({busy, done} !== 2'b10) begin
      bad++;
      $display("FAIL drain_wait: busy/done got %b, required 10", {busy, done});
    end
    core_ready = 4'hF;
    step(1'b1);
    total++;
    if ({busy, done, found} !== 3'b010) begin
      bad++;
      $display("FAIL drain_exit: got %b, required 010", {busy, done, found});
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL partial_pending: got %0d missing dispatches, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_match();
    do_reset();
    core_ready = 4'hF;
    expect_disp(0, 32'd100, 1);
    expect_disp(1, 32'd101, 2);
    launch(32'd100, 32'd200);
    step(1'b1);
    step(1'b1);
    core_match = 4'b0110;
    core_match_idx[1*IW +: IW] = 32'h0000_1234;
    core_match_idx[2*IW +: IW] = 32'h0000_5678;
    step(1'b1);
    total++;
    if ({busy, done, found} !== 3'b011 || found_idx !== 32'h0000_1234) begin
      bad++;
      $display("FAIL match_hit: status=%b found_idx=%h, required 011 and 00001234",
               {busy, done, found}, found_idx);
    end
    core_match = 4'b0001;
    core_match_idx[0 +: IW] = 32'hDEAD_BEEF;
    step(1'b1);
    core_match = 4'h0;
    step(1'b1);
    step(1'b1);
    total++;
    if ({busy, done, found} !== 3'b011 || found_idx !== 32'h0000_1234) begin
      bad++;
      $display("FAIL match_in_done: status=%b found_idx=%h, required 011 and 00001234",
               {busy, done, found}, found_idx);
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL match_pending: got %0d missing dispatches, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_empty_single();
    do_reset();
    core_ready = 4'hF;
    launch(32'd5, 32'd4);
    total++;
    if ({busy, done, found} !== 3'b010) begin
      bad++;
      $display("FAIL empty_range: got %b, required 010", {busy, done, found});
    end
    step(1'b1);
    step(1'b1);
    expect_disp(0, 32'd7, 1);
    launch(32'd7, 32'd7);
    total++;
    if ({busy, done, found} !== 3'b100) begin
      bad++;
      $display("FAIL single_launch: got %b, required 100", {busy, done, found});
    end
    step(1'b1);
    step(1'b1);
    total++;
    if ({busy, done, found} !== 3'b010) begin
      bad++;
      $display("FAIL single_done: got %b, required 010", {busy, done, found});
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL single_pending: got %0d missing dispatches, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_full_range_top();
    do_reset();
    core_ready = 4'hF;
    expect_disp(0, 32'hFFFF_FFFE, 1);
    expect_disp(1, 32'hFFFF_FFFF, 2);
    launch(32'hFFFF_FFFE, 32'hFFFF_FFFF);
    step(1'b1);
    first_idx = 32'd0;
    last_idx = 32'd3;
    start = 1'b1;
    step(1'b1);
    start = 1'b0;
    core_ready = 4'h0;
    step(1'b1);
    start = 1'b1;
    step(1'b1);
    start = 1'b0;
    total++;
    if ({busy, done, found} !== 3'b100) begin
      bad++;
      $display("FAIL top_drain_status: got %b, required 100", {busy, done, found});
    end
    rst_n = 1'b0;
    step(1'b1);
    total++;
    if ({core_valid, core_idx, busy, found, found_idx, done} !== 71'd0) begin
      bad++;
      $display("FAIL reset_mid_drain: got %h, required 0",
               {core_valid, core_idx, busy, found, found_idx, done});
    end
    rst_n = 1'b1;
    core_ready = 4'hF;
    step(1'b1);
    step(1'b1);
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL top_pending: got %0d missing dispatches, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_tick_held();
    do_reset();
    core_ready = 4'hF;
    first_idx = 32'd50;
    last_idx = 32'd51;
    start = 1'b1;
    step(1'b1);
    tick_num = 0;
    expect_disp(0, 32'd50, 1);
    expect_disp(1, 32'd51, 2);
    step(1'b1);
    start = 1'b0;
    step(1'b1);
    total++;
    if ({busy, done, found} !== 3'b100) begin
      bad++;
      $display("FAIL held_status: got %b, required 100", {busy, done, found});
    end
    rst_n = 1'b0;
    step(1'b1);
    total++;
    if ({core_valid, core_idx, busy, found, found_idx, done} !== 71'd0) begin
      bad++;
      $display("FAIL reset_clears_valid: got %h, required 0",
               {core_valid, core_idx, busy, found, found_idx, done});
    end
    rst_n = 1'b1;
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL held_pending: got %0d missing dispatches, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_partial_ready();
    test_match();
    test_empty_single();
    test_full_range_top();
    test_tick_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
